// File: rtl/npc_pkg.sv
// Shared definitions for the NPC core: reset vector, AXI response codes and
// the fetch-stage state encoding.
package npc_pkg;

  localparam logic [31:0] NPC_RESET_PC    = 32'h8000_0000;

  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;

  localparam logic [1:0]  IFU_ST_REQ      = 2'b00;
  localparam logic [1:0]  IFU_ST_RESP     = 2'b01;
  localparam logic [1:0]  IFU_ST_HOLD     = 2'b10;

  typedef enum logic [1:0] {
    ST_REQ  = IFU_ST_REQ,
    ST_RESP = IFU_ST_RESP,
    ST_HOLD = IFU_ST_HOLD
  } ifu_state_e;

endpackage

// File: rtl/ifu_fetch_axi.sv
// Instruction fetch stage: one AXI4-Lite read per instruction, bundle handed to
// decode over valid/ready, with PC redirect and single wrong-path beat discard.
module ifu_fetch_axi
  import npc_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(NPC_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [DATA_W-1:0] instF,
  output logic [ADDR_W-1:0] pcF,
  output logic [ADDR_W-1:0] snpcF,
  output logic              faultF,
  output logic              m_valid,
  input  logic              m_ready
);

  localparam logic [ADDR_W-1:0] INST_BYTES = ADDR_W'(32'd4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(32'd3);

  ifu_state_e        state_r;
  logic [ADDR_W-1:0] pc_r;
  logic              flush_pending_r;
  logic [ADDR_W-1:0] araddr_r;
  logic              arvalid_r;
  logic              rready_r;
  logic              m_valid_r;
  logic [DATA_W-1:0] inst_r;
  logic [ADDR_W-1:0] pc_f_r;
  logic [ADDR_W-1:0] snpc_f_r;
  logic              fault_r;

  logic [ADDR_W-1:0] redirect_tgt_s;
  logic [ADDR_W-1:0] pc_inc_s;

  assign redirect_tgt_s = redirect_pc & ALIGN_MASK;
  assign pc_inc_s       = pc_r + INST_BYTES;

  // Fetch FSM: request, wait for the beat, hold the bundle until decode takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_REQ;
      pc_r            <= RESET_PC;
      flush_pending_r <= 1'b0;
      araddr_r        <= RESET_PC;
      arvalid_r       <= 1'b1;
      rready_r        <= 1'b0;
      m_valid_r       <= 1'b0;
      inst_r          <= '0;
      pc_f_r          <= RESET_PC;
      snpc_f_r        <= '0;
      fault_r         <= 1'b0;
    end else begin
      case (state_r)
        ST_REQ: begin
          // An issued request is never retracted; the redirect only marks its beat stale.
          if (redirect_valid) begin
            pc_r            <= redirect_tgt_s;
            flush_pending_r <= 1'b1;
          end
          if (arready) begin
            state_r   <= ST_RESP;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rvalid) begin
            rready_r <= 1'b0;
            if (flush_pending_r || redirect_valid) begin
              flush_pending_r <= 1'b0;
              state_r         <= ST_REQ;
              arvalid_r       <= 1'b1;
              if (redirect_valid) begin
                pc_r     <= redirect_tgt_s;
                araddr_r <= redirect_tgt_s;
              end else begin
                araddr_r <= pc_r;
              end
            end else begin
              inst_r    <= rdata;
              pc_f_r    <= pc_r;
              snpc_f_r  <= pc_inc_s;
              fault_r   <= (rresp != AXI_RESP_OKAY);
              state_r   <= ST_HOLD;
              m_valid_r <= 1'b1;
            end
          end else if (redirect_valid) begin
            pc_r            <= redirect_tgt_s;
            flush_pending_r <= 1'b1;
          end
        end
        ST_HOLD: begin
          // Redirect wins over a coincident handshake: decode is flushed by it too.
          if (redirect_valid) begin
            pc_r      <= redirect_tgt_s;
            araddr_r  <= redirect_tgt_s;
            state_r   <= ST_REQ;
            arvalid_r <= 1'b1;
            m_valid_r <= 1'b0;
          end else if (m_ready) begin
            pc_r      <= pc_inc_s;
            araddr_r  <= pc_inc_s;
            state_r   <= ST_REQ;
            arvalid_r <= 1'b1;
            m_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r         <= ST_REQ;
          flush_pending_r <= 1'b0;
          araddr_r        <= pc_r;
          arvalid_r       <= 1'b1;
          rready_r        <= 1'b0;
          m_valid_r       <= 1'b0;
        end
      endcase
    end
  end

  assign araddr  = araddr_r;
  assign arvalid = arvalid_r;
  assign rready  = rready_r;
  assign instF   = inst_r;
  assign pcF     = pc_f_r;
  assign snpcF   = snpc_f_r;
  assign faultF  = fault_r;
  assign m_valid = m_valid_r;

endmodule

// File: tb/tb_ifu_fetch_axi.sv
// Self-checking bench for ifu_fetch_axi: behavioural AXI memory, stream-level
// reference model of the expected PC sequence, directed scenarios then random traffic.
module tb_ifu_fetch_axi;
  import npc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] instF;
  logic [31:0] pcF;
  logic [31:0] snpcF;
  logic        faultF;
  logic        m_valid;
  logic        m_ready;

  always #5 clk = ~clk;

  ifu_fetch_axi #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .instF(instF), .pcF(pcF), .snpcF(snpcF), .faultF(faultF),
    .m_valid(m_valid), .m_ready(m_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Instruction memory contents and response codes, as pure functions of address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000)      return 32'h0000_0413;
    else if (a == 32'h8000_0010) return 32'hDEAD_BEEF;
    else                         return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  function automatic logic [1:0] mem_resp(input logic [31:0] a);
    if (a == 32'h8000_0010)            return AXI_RESP_SLVERR;
    else if ((a[12:2] % 13) == 7)      return AXI_RESP_SLVERR;
    else                               return AXI_RESP_OKAY;
  endfunction

  // ---------------- AXI memory ----------------
  int          ar_delay_cfg = 0;
  int          r_delay_cfg  = 0;
  bit          rand_delays  = 1'b0;
  int          ar_cnt, r_cnt;
  bit          mem_busy;
  logic [31:0] mem_addr, cap_addr;
  bit          m_ar_fire, m_r_fire;

  function automatic int pick_ar();
    return rand_delays ? int'($urandom_range(0, 3)) : ar_delay_cfg;
  endfunction
  function automatic int pick_r();
    return rand_delays ? int'($urandom_range(0, 3)) : r_delay_cfg;
  endfunction

  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    mem_busy = 1'b0; ar_cnt = 0; r_cnt = 0; mem_addr = 32'h0;
    forever begin
      @(negedge clk);
      m_ar_fire = arvalid && arready;
      m_r_fire  = rvalid && rready;
      cap_addr  = araddr;
      @(posedge clk);
      #1;
      if (rst) begin
        arready = 1'b0; rvalid = 1'b0; mem_busy = 1'b0; ar_cnt = pick_ar();
      end else begin
        if (m_r_fire) begin
          rvalid = 1'b0; mem_busy = 1'b0; ar_cnt = pick_ar();
          rdata = $urandom; rresp = 2'($urandom_range(0, 3));
        end
        if (m_ar_fire) begin
          arready = 1'b0; mem_busy = 1'b1; mem_addr = cap_addr; r_cnt = pick_r();
        end
        if (!mem_busy && !arready) begin
          if (ar_cnt == 0) arready = 1'b1;
          else if (arvalid) ar_cnt--;
        end
        if (mem_busy && !rvalid) begin
          if (r_cnt == 0) begin
            rvalid = 1'b1; rdata = mem_word(mem_addr); rresp = mem_resp(mem_addr);
          end else begin
            r_cnt--;
          end
        end
      end
    end
  end

  // ---------------- reference model and per-cycle compare ----------------
  logic [31:0] exp_pc;
  int          n_xfer = 0;
  int          outstanding;
  bit          prev_ar_stall, prev_hold, prev_arvalid;
  logic [31:0] prev_araddr;
  bit          ev_xfer, ev_redir, ev_arf, ev_rf;
  logic [31:0] ev_redir_pc;

  initial begin
    exp_pc = 32'h8000_0000; outstanding = 0;
    prev_ar_stall = 1'b0; prev_hold = 1'b0; prev_arvalid = 1'b0; prev_araddr = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_pc = 32'h8000_0000; outstanding = 0;
        prev_ar_stall = 1'b0; prev_hold = 1'b0; prev_arvalid = 1'b0;
      end else begin
        if (m_valid) begin
          check("bundle_pc", pcF, exp_pc);
          check("bundle_snpc", snpcF, exp_pc + 32'd4);
          check("bundle_inst", instF, mem_word(exp_pc));
          check("bundle_fault", {31'd0, faultF}, {31'd0, mem_resp(exp_pc) != AXI_RESP_OKAY});
        end
        if (prev_hold) check("hold_valid", {31'd0, m_valid}, 32'd1);
        if (prev_ar_stall) begin
          check("ar_stable_valid", {31'd0, arvalid}, 32'd1);
          check("ar_stable_addr", araddr, prev_araddr);
        end
        if (arvalid && !prev_arvalid) check("ar_fresh_addr", araddr, exp_pc);
        if (arvalid) check("ar_one_outstanding", outstanding, 32'd0);
        if (rready) begin
          check("rready_exclusive", {30'd0, arvalid, m_valid}, 32'd0);
          check("rready_outstanding", outstanding, 32'd1);
        end
        ev_xfer     = m_valid && m_ready && !redirect_valid;
        ev_redir    = redirect_valid;
        ev_redir_pc = {redirect_pc[31:2], 2'b00};
        ev_arf      = arvalid && arready;
        ev_rf       = rvalid && rready;
        prev_ar_stall = arvalid && !arready;
        prev_araddr   = araddr;
        prev_hold     = m_valid && !m_ready && !redirect_valid;
        prev_arvalid  = arvalid && !arready;
        @(posedge clk);
        if (ev_xfer) begin exp_pc = exp_pc + 32'd4; n_xfer++; end
        if (ev_redir) exp_pc = ev_redir_pc;
        if (ev_arf) outstanding++;
        if (ev_rf)  outstanding--;
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic wait_mvalid(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (m_valid) ok = 1'b1;
    end
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: m_valid not seen within 100 cycles", name);
  endtask

  task automatic wait_ar(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (arvalid) ok = 1'b1;
    end
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: arvalid not seen within 100 cycles", name);
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = target;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  int t0, t1, xfer_before;
  logic [31:0] held_pc;

  initial begin
    rst = 1'b1; m_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_arvalid", {31'd0, arvalid}, 32'd1);
    check("rst_araddr", araddr, 32'h8000_0000);
    check("rst_rready", {31'd0, rready}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_instF", instF, 32'h0);
    check("rst_pcF", pcF, 32'h8000_0000);
    check("rst_snpcF", snpcF, 32'h0);
    check("rst_faultF", {31'd0, faultF}, 32'd0);
    rst = 1'b0; m_ready = 1'b1;

    // First fetch and 3-cycle throughput.
    @(negedge clk);
    check("t1_araddr0", araddr, 32'h8000_0000);
    wait_mvalid("t1_first");
    t0 = cyc;
    check("t1_pcF", pcF, 32'h8000_0000);
    check("t1_snpcF", snpcF, 32'h8000_0004);
    check("t1_instF", instF, 32'h0000_0413);
    wait_ar("t1_second_ar");
    check("t1_araddr1", araddr, 32'h8000_0004);
    wait_mvalid("t1_second");
    t1 = cyc;
    check("t1_throughput", t1 - t0, 32'd3);

    // Decode back-pressure for five cycles, then exactly one transfer.
    @(posedge clk); #1; m_ready = 1'b0;
    wait_mvalid("t2_hold");
    held_pc = pcF;
    check("t2_held_pc", held_pc, 32'h8000_0008);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold_valid", {31'd0, m_valid}, 32'd1);
      check("t2_hold_pc", pcF, held_pc);
      check("t2_no_ar", {31'd0, arvalid}, 32'd0);
    end
    @(posedge clk); #1; m_ready = 1'b1;
    @(posedge clk); #1; m_ready = 1'b0; ar_delay_cfg = 3;
    @(negedge clk);
    check("t2_dropped_valid", {31'd0, m_valid}, 32'd0);
    wait_mvalid("t2_next");
    check("t2_next_pc", pcF, held_pc + 32'd4);

    // Slow arready with a redirect while the request waits.
    @(posedge clk); #1; m_ready = 1'b1;
    wait_ar("t3_ar");
    check("t3_araddr", araddr, 32'h8000_0010);
    check("t3_arready_low", {31'd0, arready}, 32'd0);
    pulse_redirect(32'h8000_0103);
    ar_delay_cfg = 0;
    @(negedge clk);
    check("t3_ar_still_valid", {31'd0, arvalid}, 32'd1);
    check("t3_ar_still_addr", araddr, 32'h8000_0010);
    wait_mvalid("t3_after_redirect");
    check("t3_pcF", pcF, 32'h8000_0100);

    // Redirect in HOLD coinciding with m_ready: not a transfer.
    @(posedge clk); #1; m_ready = 1'b0;
    wait_mvalid("t4_hold");
    check("t4_pcF", pcF, 32'h8000_0104);
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200; m_ready = 1'b1;
    @(posedge clk); #1;
    redirect_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    check("t4_m_valid_low", {31'd0, m_valid}, 32'd0);
    check("t4_arvalid", {31'd0, arvalid}, 32'd1);
    check("t4_araddr", araddr, 32'h8000_0200);
    wait_mvalid("t4_new");
    check("t4_new_pc", pcF, 32'h8000_0200);

    // Error response is delivered with faultF, next fetch is normal.
    pulse_redirect(32'h8000_0010);
    wait_mvalid("t5_fault");
    check("t5_pcF", pcF, 32'h8000_0010);
    check("t5_instF", instF, 32'hDEAD_BEEF);
    check("t5_faultF", {31'd0, faultF}, 32'd1);
    @(posedge clk); #1; m_ready = 1'b1;
    @(posedge clk); #1; m_ready = 1'b0;
    wait_mvalid("t5_next");
    check("t5_next_pc", pcF, 32'h8000_0014);
    check("t5_next_fault", {31'd0, faultF}, 32'd0);

    // PC wrap at the top of the address space.
    pulse_redirect(32'hFFFF_FFFC);
    wait_mvalid("t6_wrap");
    check("t6_pcF", pcF, 32'hFFFF_FFFC);
    check("t6_snpcF", snpcF, 32'h0000_0000);
    @(posedge clk); #1; m_ready = 1'b1;
    wait_ar("t6_ar");
    check("t6_araddr", araddr, 32'h0000_0000);

    // Random traffic: memory latency, back-pressure and redirects.
    rand_delays = 1'b1;
    xfer_before = n_xfer;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      m_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      else redirect_pc = 32'h8000_0000 + $urandom_range(0, 32'h3FF);
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0; m_ready = 1'b1;
    repeat (20) @(posedge clk);
    n_checks++;
    if (n_xfer - xfer_before >= 50) n_pass++;
    else $display("FAIL random_progress: got %0d transfers expected at least 50", n_xfer - xfer_before);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
